div16_seq: RTL and testbench

DIV16_SEQ -- requirements
Module: div16_seq

---
 rtl/div16_seq.sv | 127 ++++++++++++
 tb/tb_div16_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div16_seq.sv
//------------------------------------------------------------------------------
// Module   : div16_seq
// Purpose  : Sequential unsigned restoring divider, one quotient bit per cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int C_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH-1:0]     r_dvs;
  logic [WIDTH-1:0]     r_rem;
  logic [C_CNT_W-1:0]   r_cnt;

  logic                 w_accept;
  logic                 w_zero;
  logic                 w_last;
  logic                 w_qbit;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]     w_quo_nxt;

  assign w_accept = start && (r_state != S_CALC);
  assign w_zero   = (divisor == '0);
  assign w_last   = (r_cnt == C_CNT_W'(1));

  // The partial remainder is always below the divisor, so the borrow out of
  // the WIDTH+1-bit subtraction alone tells whether the divisor fits.
  always_comb begin
    w_shift   = {r_rem, r_dvd[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_dvs};
    w_qbit    = ~w_diff[WIDTH];
    w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_nxt = {r_dvd[WIDTH-2:0], w_qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = (r_state != S_CALC);
    done        = (r_state == S_DONE);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = w_zero ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Quotient bits are shifted into the low end of the dividend register as
  // its high bits are consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      if (w_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
        r_cnt       <= '0;
      end else begin
        r_dvd <= dividend;
        r_dvs <= divisor;
        r_rem <= '0;
        r_cnt <= C_CNT_W'(WIDTH);
      end
    end else if (r_state == S_CALC) begin
      r_dvd <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt - C_CNT_W'(1);
      if (w_last) begin
        quotient    <= w_quo_nxt;
        remainder   <= w_rem_nxt;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div16_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_div16_seq
// Purpose  : Directed self-checking bench for div16_seq.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_div16_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div16_seq #(.WIDTH(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one request at a negedge and count cycles until done is seen.
  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input int elat, input logic [15:0] eq, input logic [15:0] er,
                    input logic ez);
    int n = 0;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    do begin
      @(negedge clk);
      start    = 1'b0;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      n++;
      if (n == 1 && elat > 1) check({tag, ".busy"}, 32'(ready), 32'(0));
    end while (!done && n < 40);
    check({tag, ".lat"}, 32'(n), 32'(elat));
    check({tag, ".q"}, 32'(quotient), 32'(eq));
    check({tag, ".r"}, 32'(remainder), 32'(er));
    check({tag, ".dbz"}, 32'(div_by_zero), 32'(ez));
    @(negedge clk);
    check({tag, ".pulse"}, 32'(done), 32'(0));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!done && n < 40);
  endtask

  initial begin
    int n;
    int cnt;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("rst.ready", 32'(ready), 32'(1));
    check("rst.done", 32'(done), 32'(0));
    check("rst.q", 32'(quotient), 32'(0));
    check("rst.r", 32'(remainder), 32'(0));
    check("rst.dbz", 32'(div_by_zero), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    op("d100_7", 16'd100, 16'd7, 17, 16'd14, 16'd2, 1'b0);
    op("ffff_1", 16'hFFFF, 16'd1, 17, 16'hFFFF, 16'd0, 1'b0);
    op("ffff_8001", 16'hFFFF, 16'h8001, 17, 16'd1, 16'h7FFE, 1'b0);
    op("div0", 16'd5, 16'd0, 1, 16'hFFFF, 16'd5, 1'b1);
    op("d3_10", 16'd3, 16'd10, 17, 16'd0, 16'd3, 1'b0);

    // Start during CALC must be ignored.
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    repeat (4) begin @(negedge clk); n++; end
    dividend = 16'd50; divisor = 16'd5; start = 1'b1;
    while (!done && n < 40) begin @(negedge clk); start = 1'b0; n++; end
    check("ign.lat", 32'(n), 32'(17));
    check("ign.q", 32'(quotient), 32'(14));
    check("ign.r", 32'(remainder), 32'(2));
    cnt = 0;
    repeat (20) begin @(negedge clk); if (done) cnt++; end
    check("ign.extra_done", 32'(cnt), 32'(0));

    // Back-to-back: new request in the DONE cycle.
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    wait_done(n);
    check("b2b.lat1", 32'(n), 32'(17));
    check("b2b.q1", 32'(quotient), 32'(14));
    check("b2b.r1", 32'(remainder), 32'(2));
    check("b2b.ready", 32'(ready), 32'(1));
    dividend = 16'd9; divisor = 16'd4; start = 1'b1;
    wait_done(n);
    check("b2b.lat2", 32'(n), 32'(17));
    check("b2b.q2", 32'(quotient), 32'(2));
    check("b2b.r2", 32'(remainder), 32'(1));

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.ready", 32'(ready), 32'(1));
    check("abort.done", 32'(done), 32'(0));
    check("abort.q", 32'(quotient), 32'(0));
    check("abort.r", 32'(remainder), 32'(0));
    check("abort.dbz", 32'(div_by_zero), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (25) begin @(negedge clk); if (done) cnt++; end
    check("abort.no_done", 32'(cnt), 32'(0));

    // First request right after reset release.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op("post_rst", 16'd9, 16'd4, 17, 16'd2, 16'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
